ram_arbiter_rr: RTL and testbench

- Parametrised RAM arbiter and successor to the single-core combinational memory controller.
- Serves CPUS cores, each with an icache channel and a dcache channel, onto one shared RAM port.
- Uses a registered grant, round-robin fairness across all 2*CPUS channels, abort on request drop, and a sticky RAM-timeout flag.
- Sits between the per-core cache_control signals and the RAM model.

---
 rtl/ram_arbiter_rr_if.sv | 46 ++++
 rtl/ram_arbiter_rr.sv | 175 +++++++++++++++++
 tb/tb_ram_arbiter_rr.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_rr_if.sv
// Bus bundle between the per-core cache controllers, the RAM model and ram_arbiter_rr.
// The arbiter connects through the slave modport; the cores/RAM side uses master.
interface ram_arbiter_rr_if #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int GW = $clog2(2 * CPUS);

    // Cache side
    logic [CPUS-1:0]        iREN;
    logic [CPUS*ADDR_W-1:0] iaddr;
    logic [CPUS-1:0]        iwait;
    logic [CPUS*DATA_W-1:0] iload;
    logic [CPUS-1:0]        dREN;
    logic [CPUS-1:0]        dWEN;
    logic [CPUS*ADDR_W-1:0] daddr;
    logic [CPUS*DATA_W-1:0] dstore;
    logic [CPUS-1:0]        dwait;
    logic [CPUS*DATA_W-1:0] dload;

    // RAM side
    logic                   ramREN;
    logic                   ramWEN;
    logic [ADDR_W-1:0]      ramaddr;
    logic [DATA_W-1:0]      ramstore;
    logic [DATA_W-1:0]      ramload;
    logic [1:0]             ramstate;

    // Status
    logic [GW-1:0]          grant_id;
    logic                   busy;
    logic                   timeout_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               grant_id, busy, timeout_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               grant_id, busy, timeout_err
    );
endinterface

// File: rtl/ram_arbiter_rr.sv
// Round-robin arbiter sharing one RAM port among CPUS cores (icache + dcache each),
// with a registered grant, abort on request drop and a sticky RAM-timeout flag.
module ram_arbiter_rr #(
    parameter int CPUS    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input logic            CLK,
    input logic            RST,
    ram_arbiter_rr_if.slave bus
);
    localparam int N  = 2 * CPUS;
    localparam int GW = $clog2(N);

    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [GW-1:0]     ptr, ptr_n;
    logic [GW-1:0]     gid, gid_n;
    logic [TO_W-1:0]   cnt, cnt_n, cnt_inc;
    logic              terr, terr_n;

    logic [N-1:0]      pending;
    logic [GW-1:0]     cand;
    logic [GW-1:0]     winner;
    logic              found;

    logic [GW-1:0]     g_core;
    logic              g_icache;
    logic              g_pending;
    logic [CPUS-1:0]   core_sel;
    logic              sel_iren, sel_dren, sel_dwen;
    logic [ADDR_W-1:0] sel_iaddr, sel_daddr;
    logic [DATA_W-1:0] sel_dstore;

    logic [CPUS-1:0]   iwait_c, dwait_c;
    logic              ren_c, wen_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] store_c;

    // Even channels are dcache, odd channels are icache of core (channel >> 1).
    always_comb begin
        pending = '0;
        for (int k = 0; k < CPUS; k++) begin
            pending[2*k]   = bus.dREN[k] | bus.dWEN[k];
            pending[2*k+1] = bus.iREN[k];
        end
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < N; i++) begin
            cand = GW'((int'(ptr) + i) % N);
            if (!found && pending[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign g_core   = gid >> 1;
    assign g_icache = gid[0];

    always_comb begin
        core_sel   = '0;
        sel_iren   = 1'b0;
        sel_dren   = 1'b0;
        sel_dwen   = 1'b0;
        sel_iaddr  = '0;
        sel_daddr  = '0;
        sel_dstore = '0;
        for (int k = 0; k < CPUS; k++) begin
            if (g_core == GW'(k)) begin
                core_sel[k] = 1'b1;
                sel_iren    = bus.iREN[k];
                sel_dren    = bus.dREN[k];
                sel_dwen    = bus.dWEN[k];
                sel_iaddr   = bus.iaddr[k*ADDR_W +: ADDR_W];
                sel_daddr   = bus.daddr[k*ADDR_W +: ADDR_W];
                sel_dstore  = bus.dstore[k*DATA_W +: DATA_W];
            end
        end
    end

    assign g_pending = g_icache ? sel_iren : (sel_dren | sel_dwen);
    assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gid_n   = gid;
        cnt_n   = cnt;
        terr_n  = terr;
        iwait_c = '1;
        dwait_c = '1;
        ren_c   = 1'b0;
        wen_c   = 1'b0;
        addr_c  = '0;
        store_c = '0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_n = S_GRANT;
                    gid_n   = winner;
                    cnt_n   = '0;
                end
            end
            S_GRANT: begin
                addr_c  = g_icache ? sel_iaddr : sel_daddr;
                store_c = g_icache ? '0 : sel_dstore;
                // A dropped request gates the enables off; a write wins over a read.
                if (g_pending) begin
                    wen_c = !g_icache && sel_dwen;
                    ren_c = g_icache || !sel_dwen;
                end
                if (bus.ramstate == RAM_ACCESS) begin
                    if (g_icache) iwait_c = ~core_sel;
                    else          dwait_c = ~core_sel;
                    state_n = S_IDLE;
                    ptr_n   = (gid == GW'(N - 1)) ? '0 : gid + 1'b1;
                end else if (!g_pending) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == TO_W'(TIMEOUT)) terr_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            ptr   <= '0;
            gid   <= '0;
            cnt   <= '0;
            terr  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            gid   <= gid_n;
            cnt   <= cnt_n;
            terr  <= terr_n;
        end
    end

    assign bus.iwait       = iwait_c;
    assign bus.dwait       = dwait_c;
    assign bus.iload       = {CPUS{bus.ramload}};
    assign bus.dload       = {CPUS{bus.ramload}};
    assign bus.ramREN      = ren_c;
    assign bus.ramWEN      = wen_c;
    assign bus.ramaddr     = addr_c;
    assign bus.ramstore    = store_c;
    assign bus.grant_id    = gid;
    assign bus.busy        = (state == S_GRANT);
    assign bus.timeout_err = terr;
endmodule

// File: tb/tb_ram_arbiter_rr.sv
// Directed bench for ram_arbiter_rr: stimulus pushes expected grants/acks into queues,
// a negedge monitor pops and compares whenever a grant starts or a wait bit drops.
module tb_ram_arbiter_rr;
    localparam int CPUS = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    localparam logic [1:0] R_FREE   = 2'd0;
    localparam logic [1:0] R_BUSY   = 2'd1;
    localparam logic [1:0] R_ACCESS = 2'd2;
    localparam logic [1:0] R_ERROR  = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_rr_if #(.CPUS(CPUS), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_arbiter_rr #(
        .CPUS(CPUS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(3), .TO_W(2)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    typedef struct {
        int          ch;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] data;
        logic        ren;
        logic        wen;
    } ack_t;

    ack_t ack_q[$];
    int   gnt_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iREN     = '0;
        bus.dREN     = '0;
        bus.dWEN     = '0;
        bus.iaddr    = '0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = R_FREE;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_ack(input int ch, input logic [31:0] addr, input logic [31:0] store,
                            input logic [31:0] data, input logic ren, input logic wen);
        ack_t e;
        e.ch = ch; e.addr = addr; e.store = store; e.data = data; e.ren = ren; e.wen = wen;
        ack_q.push_back(e);
    endtask

    // Monitor
    logic busy_q = 1'b0;
    int   mon_ch;
    int   mon_nlow;
    int   mon_g;
    ack_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            busy_q = 1'b0;
        end else begin
            if (bus.busy && !busy_q) begin
                if (gnt_q.size() == 0) begin
                    fail("grant", $sformatf("unexpected grant of channel %0d", bus.grant_id));
                end else begin
                    mon_g = gnt_q.pop_front();
                    check("grant_id", 64'(bus.grant_id), 64'(mon_g));
                end
            end
            busy_q   = bus.busy;
            mon_nlow = 0;
            mon_ch   = -1;
            for (int k = 0; k < CPUS; k++) begin
                if (!bus.dwait[k]) begin mon_nlow++; mon_ch = 2*k;   end
                if (!bus.iwait[k]) begin mon_nlow++; mon_ch = 2*k+1; end
            end
            if (mon_nlow != 0) begin
                check("ack_single_wait", 64'(mon_nlow), 64'd1);
                if (ack_q.size() == 0) begin
                    fail("ack", $sformatf("unexpected ack on channel %0d", mon_ch));
                end else begin
                    mon_e = ack_q.pop_front();
                    check("ack_channel", 64'(mon_ch), 64'(mon_e.ch));
                    check("ack_ramaddr", 64'(bus.ramaddr), 64'(mon_e.addr));
                    check("ack_ramstore", 64'(bus.ramstore), 64'(mon_e.store));
                    check("ack_ramREN", 64'(bus.ramREN), 64'(mon_e.ren));
                    check("ack_ramWEN", 64'(bus.ramWEN), 64'(mon_e.wen));
                    if (mon_ch % 2 == 1)
                        check("ack_iload", 64'(bus.iload[(mon_ch/2)*DW +: DW]), 64'(mon_e.data));
                    else
                        check("ack_dload", 64'(bus.dload[(mon_ch/2)*DW +: DW]), 64'(mon_e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ramREN", 64'(bus.ramREN), 64'd0);
        check("rst_ramWEN", 64'(bus.ramWEN), 64'd0);
        check("rst_ramaddr", 64'(bus.ramaddr), 64'd0);
        check("rst_ramstore", 64'(bus.ramstore), 64'd0);
        check("rst_iwait", 64'(bus.iwait), 64'h3);
        check("rst_dwait", 64'(bus.dwait), 64'h3);
        check("rst_timeout", 64'(bus.timeout_err), 64'd0);
        tick();
        rst = 1'b0;

        // Core0 icache read, ACCESS on the second GRANT cycle
        bus.iREN[0]      = 1'b1;
        bus.iaddr[31:0]  = 32'h40;
        bus.ramstate     = R_BUSY;
        gnt_q.push_back(1);
        @(negedge clk);
        check("ird_idle_busy", 64'(bus.busy), 64'd0);
        tick();
        @(negedge clk);
        check("ird_ramaddr", 64'(bus.ramaddr), 64'h40);
        check("ird_ramREN", 64'(bus.ramREN), 64'd1);
        check("ird_iwait_held", 64'(bus.iwait), 64'h3);
        tick();
        bus.ramstate = R_ACCESS;
        bus.ramload  = 32'hDEADBEEF;
        push_ack(1, 32'h40, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("ird_done_busy", 64'(bus.busy), 64'd0);
        check("ird_done_iwait", 64'(bus.iwait), 64'h3);

        // All four channels pending, ACCESS every GRANT cycle
        do_reset();
        bus.iREN     = 2'b11;
        bus.dREN     = 2'b11;
        bus.iaddr    = {32'h104, 32'h100};
        bus.daddr    = {32'h204, 32'h200};
        bus.dstore   = {32'h22222222, 32'h11111111};
        bus.ramstate = R_ACCESS;
        bus.ramload  = 32'hCAFE0001;
        gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(2);
        gnt_q.push_back(3); gnt_q.push_back(0);
        push_ack(0, 32'h200, 32'h11111111, 32'hCAFE0001, 1'b1, 1'b0);
        push_ack(1, 32'h100, 32'h0,        32'hCAFE0001, 1'b1, 1'b0);
        push_ack(2, 32'h204, 32'h22222222, 32'hCAFE0001, 1'b1, 1'b0);
        push_ack(3, 32'h104, 32'h0,        32'hCAFE0001, 1'b1, 1'b0);
        push_ack(0, 32'h200, 32'h11111111, 32'hCAFE0001, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rr_busy_pattern", 64'(bus.busy), 64'((i % 2) == 1));
            tick();
        end
        idle_inputs();

        // Core1 dcache with dREN and dWEN both set: write wins
        bus.dREN[1]       = 1'b1;
        bus.dWEN[1]       = 1'b1;
        bus.daddr[63:32]  = 32'h80;
        bus.dstore[63:32] = 32'h12345678;
        bus.ramstate      = R_BUSY;
        gnt_q.push_back(2);
        @(negedge clk);
        check("wr_idle_busy", 64'(bus.busy), 64'd0);
        tick();
        @(negedge clk);
        check("wr_ramWEN", 64'(bus.ramWEN), 64'd1);
        check("wr_ramREN", 64'(bus.ramREN), 64'd0);
        check("wr_ramaddr", 64'(bus.ramaddr), 64'h80);
        check("wr_ramstore", 64'(bus.ramstore), 64'h12345678);
        check("wr_dwait_held", 64'(bus.dwait), 64'h3);
        tick();
        bus.ramstate = R_ACCESS;
        bus.ramload  = 32'h77777777;
        push_ack(2, 32'h80, 32'h12345678, 32'h77777777, 1'b0, 1'b1);
        tick();
        idle_inputs();

        // Abort: ptr is 3 here; the dropped ch1 grant must not move it
        bus.iREN[0]     = 1'b1;
        bus.iaddr[31:0] = 32'h40;
        bus.ramstate    = R_BUSY;
        gnt_q.push_back(1);
        @(negedge clk);
        check("ab_idle_busy", 64'(bus.busy), 64'd0);
        tick();
        bus.iREN[0] = 1'b0;
        @(negedge clk);
        check("ab_busy", 64'(bus.busy), 64'd1);
        check("ab_ramREN", 64'(bus.ramREN), 64'd0);
        check("ab_ramWEN", 64'(bus.ramWEN), 64'd0);
        check("ab_iwait", 64'(bus.iwait), 64'h3);
        tick();
        bus.iREN[0]       = 1'b1;
        bus.dREN[1]       = 1'b1;
        bus.daddr[63:32]  = 32'h300;
        bus.dstore[63:32] = 32'h33333333;
        bus.ramstate      = R_ACCESS;
        bus.ramload       = 32'h0BADF00D;
        gnt_q.push_back(1);
        gnt_q.push_back(2);
        push_ack(1, 32'h40,  32'h0,        32'h0BADF00D, 1'b1, 1'b0);
        push_ack(2, 32'h300, 32'h33333333, 32'h0BADF00D, 1'b1, 1'b0);
        @(negedge clk);
        check("ab_back_to_idle", 64'(bus.busy), 64'd0);
        tick();
        tick();
        tick();
        tick();
        idle_inputs();

        // Timeout with TIMEOUT=3, RAM stuck in ERROR
        do_reset();
        bus.dREN[0]       = 1'b1;
        bus.daddr[31:0]   = 32'h500;
        bus.dstore[31:0]  = 32'h55555555;
        bus.ramstate      = R_ERROR;
        gnt_q.push_back(0);
        @(negedge clk);
        check("to_idle_busy", 64'(bus.busy), 64'd0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            @(negedge clk);
            check("to_busy_held", 64'(bus.busy), 64'd1);
            check("to_flag", 64'(bus.timeout_err), 64'(c == 4));
        end
        tick();
        bus.ramstate = R_ACCESS;
        bus.ramload  = 32'h5A5A5A5A;
        push_ack(0, 32'h500, 32'h55555555, 32'h5A5A5A5A, 1'b1, 1'b0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("to_sticky_busy", 64'(bus.busy), 64'd0);
        check("to_sticky_flag", 64'(bus.timeout_err), 64'd1);
        tick();
        @(negedge clk);
        check("to_sticky_flag2", 64'(bus.timeout_err), 64'd1);
        do_reset();
        @(negedge clk);
        check("to_cleared", 64'(bus.timeout_err), 64'd0);

        check("grants_drained", 64'(gnt_q.size()), 64'd0);
        check("acks_drained", 64'(ack_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
